// File: rtl/itof_pkg.sv
// Shared constants, stage payload type and round/pack helpers for int_to_float.
// Build option ITOF_RNE_EN selects round-to-nearest-even; otherwise the pack truncates toward zero.
package itof_pkg;

    localparam int EXP_BIAS = 127;
    localparam int INT_W    = 32;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_TOP  = 158;

    typedef struct packed {
        logic               sign;
        logic               zero;
        logic [EXP_W-1:0]   exp;
        logic [INT_W-1:0]   norm;
    } norm_t;

    // Two's-complement magnitude; -2^31 maps to 0x80000000 as an unsigned value.
    function automatic logic [INT_W-1:0] abs_mag(input logic [INT_W-1:0] a);
        return a[INT_W-1] ? (~a + 32'd1) : a;
    endfunction

    function automatic logic [INT_W-1:0] round_pack(input norm_t p);
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
`ifdef ITOF_RNE_EN
        logic              guard;
        logic              sticky;
        logic              inc;
        logic [MANT_W:0]   sum;
`endif
        mant = p.norm[INT_W-2:INT_W-1-MANT_W];
        exp  = p.exp;
`ifdef ITOF_RNE_EN
        guard  = p.norm[7];
        sticky = |p.norm[6:0];
        inc    = guard & (sticky | mant[0]);
        sum    = {1'b0, mant} + {23'd0, inc};
        // A carry out of the mantissa leaves it all zeros and bumps the exponent.
        mant   = sum[MANT_W-1:0];
        exp    = exp + {7'd0, sum[MANT_W]};
`endif
        return p.zero ? 32'h0000_0000 : {p.sign, exp, mant};
    endfunction

endpackage

// File: rtl/int_to_float_lzc32.sv
// Combinational 32-bit leading-zero counter; valid is low for a zero input.
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  cnt,
    output logic        valid
);

    logic [15:0] x16_s;
    logic [7:0]  x8_s;
    logic [3:0]  x4_s;
    logic [1:0]  x2_s;

    // Binary search: each level keeps the half window that holds the leading one.
    always_comb begin
        cnt    = 5'd0;
        cnt[4] = (a[31:16] == 16'h0000);
        x16_s  = cnt[4] ? a[15:0] : a[31:16];
        cnt[3] = (x16_s[15:8] == 8'h00);
        x8_s   = cnt[3] ? x16_s[7:0] : x16_s[15:8];
        cnt[2] = (x8_s[7:4] == 4'h0);
        x4_s   = cnt[2] ? x8_s[3:0] : x8_s[7:4];
        cnt[1] = (x4_s[3:2] == 2'b00);
        x2_s   = cnt[1] ? x4_s[1:0] : x4_s[3:2];
        cnt[0] = ~x2_s[1];
        valid  = |x2_s;
    end

endmodule

// File: rtl/int_to_float.sv
// Pipelined signed 32-bit integer to IEEE-754 single converter with stb/ack flow control.
// out_reg=1 registers the pack stage (latency 3); out_reg=0 packs combinationally (latency 2).
module int_to_float
    import itof_pkg::*;
#(
    parameter bit out_reg = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] itof_a,
    input  logic        itof_a_stb,
    output logic        itof_a_ack,
    output logic [31:0] itof_z,
    output logic        itof_z_stb,
    input  logic        itof_z_ack
);

    logic        s1_valid_r;
    logic        s1_sign_r;
    logic        s1_zero_r;
    logic [31:0] s1_mag_r;
    logic        s2_valid_r;
    norm_t       s2_pay_r;
    norm_t       s2_next_s;
    logic        ld1_s;
    logic        ld2_s;
    logic        ld_out_s;
    logic [4:0]  lz_s;
    logic        lz_valid_s;

    // A stage loads when empty or when its successor takes its contents this cycle.
    assign ld2_s      = ~s2_valid_r | ld_out_s;
    assign ld1_s      = ~s1_valid_r | ld2_s;
    assign itof_a_ack = ld1_s;

    lzc32 u_lzc (
        .a     (s1_mag_r),
        .cnt   (lz_s),
        .valid (lz_valid_s)
    );

    // Stage-2 payload: normalise the magnitude and derive the biased exponent.
    always_comb begin
        s2_next_s      = '0;
        s2_next_s.sign = s1_sign_r;
        s2_next_s.zero = s1_zero_r | ~lz_valid_s;
        s2_next_s.exp  = 8'(EXP_TOP) - {3'b000, lz_s};
        s2_next_s.norm = s1_mag_r << lz_s;
    end

    // Stage 1: sign, magnitude and zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
        end else if (ld1_s) begin
            s1_valid_r <= itof_a_stb;
            if (itof_a_stb) begin
                s1_sign_r <= itof_a[31];
                s1_mag_r  <= abs_mag(itof_a);
                s1_zero_r <= (itof_a == 32'h0000_0000);
            end
        end
    end

    // Stage 2: normalised payload; cleared on reset since it drives itof_z when out_reg=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_pay_r   <= '0;
        end else if (ld2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_pay_r <= s2_next_s;
            end
        end
    end

    generate
        if (out_reg) begin : g_out_reg
            logic        s3_valid_r;
            logic [31:0] z_r;

            assign ld_out_s   = ~s3_valid_r | itof_z_ack;
            assign itof_z     = z_r;
            assign itof_z_stb = s3_valid_r;

            // Stage 3: round and pack into the output register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s3_valid_r <= 1'b0;
                    z_r        <= 32'h0000_0000;
                end else if (ld_out_s) begin
                    s3_valid_r <= s2_valid_r;
                    if (s2_valid_r) begin
                        z_r <= round_pack(s2_pay_r);
                    end
                end
            end
        end else begin : g_out_comb
            assign ld_out_s   = itof_z_ack;
            assign itof_z     = round_pack(s2_pay_r);
            assign itof_z_stb = s2_valid_r;
        end
    endgenerate

endmodule
